// File: rtl/adder_pkg.sv
// Shared definitions for the iterative adder: controller states and chunk-count helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Number of chunk cycles an operation takes; WIDTH must be a multiple of CHUNK.
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit full adder used for one slice per cycle.
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  end

endmodule

// File: rtl/iter_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, LSB first,
// carry rippled through a register, start/done handshake.
module iter_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_stage;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_stage_next;
  logic             w_accept;
  logic             w_last;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_idx == LAST_IDX);

  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_slice = r_a[i*CHUNK +: CHUNK];
        w_b_slice = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .a (w_a_slice),
    .b (w_b_slice),
    .ci(r_carry),
    .s (w_s),
    .co(w_co)
  );

  // Staging with the current slice merged in, so the final slice reaches sum on the same edge.
  always_comb begin
    w_stage_next = r_stage;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_stage_next[i*CHUNK +: CHUNK] = w_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = start ? RUN : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_stage <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_stage <= w_stage_next;
      r_carry <= w_co;
      r_idx   <= w_last ? '0 : r_idx + IDXW'(1);
      if (w_last) begin
        r_sum  <= w_stage_next;
        r_cout <= w_co;
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_stage_next[WIDTH-1] != r_a[WIDTH-1]);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_iter_adder.sv
// Bench for iter_adder: 32/8 and 8/8 instances checked every cycle against an arithmetic model.
module tb_iter_adder;

  localparam int W   = 32;
  localparam int C   = 8;
  localparam int N   = W / C;
  localparam int W8  = 8;
  localparam int N8  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, sub, cin;
  logic [31:0] a, b;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int checks = 0;
  int errors = 0;

  iter_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  iter_adder #(.WIDTH(W8), .CHUNK(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  initial begin
    assert (W % C == 0) else $fatal(1, "FAIL width_multiple W=%0d C=%0d", W, C);
  end

  // Reference: {ovf, cout, sum} from integer arithmetic on w-bit operands.
  function automatic logic [33:0] ref_op(input logic [31:0] ta, input logic [31:0] tb,
                                         input logic tc, input logic ts, input int w);
    longint mask, half, ua, ub, sa, sb, u, s, c;
    logic   co, ov;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(ta) & mask;
    ub   = longint'(tb) & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    c    = longint'(tc);
    if (ts) begin
      u  = ua - ub - c;
      co = (ua >= ub + c);
      s  = sa - sb - c;
    end else begin
      u  = ua + ub + c;
      co = (u > mask);
      s  = sa + sb + c;
    end
    ov = (s >= half) || (s < -half);
    return {ov, co, 32'(u & mask)};
  endfunction

  logic [33:0] w_ref32, w_ref8;
  assign w_ref32 = ref_op(a, b, cin, sub, W);
  assign w_ref8  = ref_op({24'b0, a8}, {24'b0, b8}, cin8, sub8, W8);

  int          m_left, m8_left;
  logic        m_done, m_cout, m_ovf, p_cout, p_ovf;
  logic [31:0] m_sum, p_sum;
  logic        m8_done, m8_cout, m8_ovf, p8_cout, p8_ovf;
  logic [7:0]  m8_sum, p8_sum;

  // Model: an accepted op occupies N busy cycles, then a one-cycle done with its result.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      m8_left <= 0; m8_done <= 1'b0; m8_sum <= '0; m8_cout <= 1'b0; m8_ovf <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1; m_sum <= p_sum; m_cout <= p_cout; m_ovf <= p_ovf;
        end
      end else if (start) begin
        m_left <= N;
        p_sum <= w_ref32[31:0]; p_cout <= w_ref32[32]; p_ovf <= w_ref32[33];
      end
      m8_done <= 1'b0;
      if (m8_left > 0) begin
        m8_left <= m8_left - 1;
        if (m8_left == 1) begin
          m8_done <= 1'b1; m8_sum <= p8_sum; m8_cout <= p8_cout; m8_ovf <= p8_ovf;
        end
      end else if (start8) begin
        m8_left <= N8;
        p8_sum <= w_ref8[7:0]; p8_cout <= w_ref8[32]; p8_ovf <= w_ref8[33];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("sum",  sum, m_sum);
    chk("cout", 32'(cout), 32'(m_cout));
    chk("ovf",  32'(ovf), 32'(m_ovf));
    chk("busy8", 32'(busy8), 32'(m8_left != 0));
    chk("done8", 32'(done8), 32'(m8_done));
    chk("sum8",  32'(sum8), 32'(m8_sum));
    chk("cout8", 32'(cout8), 32'(m8_cout));
    chk("ovf8",  32'(ovf8), 32'(m8_ovf));
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       input logic ts, output int lat, output int nbusy);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    lat = 0; nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      step();
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic ts, output int lat);
    a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    lat = 0;
    while (!done8 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat, nb;
    start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    @(posedge clk); #1;
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    step();

    run32(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lat, nb);
    chk("lat_basic", 32'(lat), 4);
    chk("busy_cycles", 32'(nb), 4);
    chk("sum_basic", sum, 32'h00000100);
    chk("cout_basic", 32'(cout), 0);
    chk("ovf_basic", 32'(ovf), 0);
    step();

    run32(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lat, nb);
    chk("sum_chain", sum, 32'h00000000);
    chk("cout_chain", 32'(cout), 1);
    chk("ovf_chain", 32'(ovf), 0);
    step();

    run32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat, nb);
    chk("sum_ovf", sum, 32'h80000000);
    chk("cout_ovf", 32'(cout), 0);
    chk("ovf_ovf", 32'(ovf), 1);
    step();

    run32(32'd5, 32'd7, 1'b0, 1'b1, lat, nb);
    chk("sum_sub1", sum, 32'hFFFFFFFE);
    chk("cout_sub1", 32'(cout), 0);
    chk("ovf_sub1", 32'(ovf), 0);
    step();

    run32(32'd7, 32'd5, 1'b1, 1'b1, lat, nb);
    chk("sum_sub2", sum, 32'h00000001);
    chk("cout_sub2", 32'(cout), 1);
    chk("ovf_sub2", 32'(ovf), 0);
    step();

    // start pulsed mid-RUN must be dropped
    a = 32'h10; b = 32'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    a = 32'h1000; b = 32'h2000; sub = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin step(); lat++; end
    chk("lat_ignore", 32'(lat), 4);
    chk("sum_ignore", sum, 32'h30);
    step();
    chk("no_queue_busy", 32'(busy), 0);
    step();
    chk("no_queue_done", 32'(done), 0);

    // back-to-back: start held in the DONE cycle
    run32(32'd1, 32'd1, 1'b0, 1'b0, lat, nb);
    chk("sum_b2b_first", sum, 32'd2);
    a = 32'h100; b = 32'h200; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      chk("sum_hold", sum, 32'd2);
      step();
      lat++;
    end
    chk("lat_b2b", 32'(lat), 4);
    chk("sum_b2b", sum, 32'h300);
    step();

    // reset during the third RUN cycle
    a = 32'hAAAA; b = 32'h5555; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("busy_pre_rst", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_sum", sum, 0);
    chk("mrst_cout", 32'(cout), 0);
    chk("mrst_ovf", 32'(ovf), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("no_done_after_rst", 32'(done), 0);
      step();
    end
    run32(32'd1, 32'd2, 1'b0, 1'b0, lat, nb);
    chk("sum_after_rst", sum, 32'd3);
    step();

    // NCHUNK = 1 instance
    run8(8'h80, 8'h80, 1'b0, 1'b0, lat);
    chk("lat8", 32'(lat), 1);
    chk("sum8_lit", 32'(sum8), 0);
    chk("cout8_lit", 32'(cout8), 1);
    chk("ovf8_lit", 32'(ovf8), 1);
    step();

    for (int i = 0; i < 200; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), lat);
      chk("lat8_rand", 32'(lat), 1);
      if ($urandom_range(0, 1) == 1) step();
    end

    for (int i = 0; i < 40; i++) begin
      run32($urandom, $urandom, 1'($urandom), 1'($urandom), lat, nb);
      chk("lat32_rand", 32'(lat), 4);
      if ($urandom_range(0, 1) == 1) step();
    end

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
